hough_frame_sequencer: RTL and testbench

Per-frame controller between the VIP flow-control wrapper and the Hough core datapath. Consumes control packets and re-issues them downstream. Gates pixel read/write, generates pixel coordinates and frame markers for the accumulator, and schedules the Hough vote/peak engine at end of frame. The engine runs concurrently with streaming of the next frame. Overlay enable and overrun status are tracked per frame.

---
 rtl/hough_frame_sequencer.sv | 142 ++++++++++++++
 tb/tb_hough_frame_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hough_frame_sequencer.sv
// Per-frame sequencer between the VIP flow-control wrapper and the Hough core.
// Re-issues control packets, streams pixels with coordinates, and schedules the vote/peak engine.
module hough_frame_sequencer #(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned HEIGHT = 288,
  parameter int unsigned OVR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_in,
  input  logic             stall_out,
  input  logic             vip_ctrl_valid,
  input  logic [15:0]      width_in,
  input  logic [15:0]      height_in,
  input  logic [3:0]       interlaced_in,
  input  logic             end_of_video,
  input  logic             vip_ctrl_busy,
  output logic             read,
  output logic             write,
  output logic             vip_ctrl_send,
  output logic [15:0]      width_out,
  output logic [15:0]      height_out,
  output logic [3:0]       interlaced_out,
  output logic             end_of_video_out,
  output logic             pix_en,
  output logic [15:0]      pix_x,
  output logic [15:0]      pix_y,
  output logic             sof,
  output logic             eof,
  output logic             hough_start,
  input  logic             hough_busy,
  output logic             overlay_en,
  output logic             size_err,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam logic [15:0] ExpW  = 16'(WIDTH);
  localparam logic [15:0] ExpH  = 16'(HEIGHT);
  localparam logic [15:0] LastX = 16'(WIDTH - 1);
  localparam logic [15:0] LastY = 16'(HEIGHT - 1);

  typedef enum logic [1:0] {StWaitCtrl, StSendCtrl, StStream, StDrain} state_e;

  state_e state;
  logic   xfer;
  logic   at_last;
  logic   lines_ready;
  logic   start_pending;
  logic   busy_q;

  always_comb begin
    xfer             = ~stall_in & ~stall_out;
    read             = xfer & ((state == StStream) | (state == StDrain));
    write            = read;
    pix_en           = xfer & (state == StStream) & ~size_err;
    at_last          = (pix_x == LastX) & (pix_y == LastY);
    sof              = pix_en & (pix_x == 16'd0) & (pix_y == 16'd0);
    eof              = pix_en & at_last;
    end_of_video_out = read & end_of_video;
    vip_ctrl_send    = (state == StSendCtrl) & ~vip_ctrl_busy;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= StWaitCtrl;
      width_out      <= '0;
      height_out     <= '0;
      interlaced_out <= '0;
      pix_x          <= '0;
      pix_y          <= '0;
      hough_start    <= 1'b0;
      overlay_en     <= 1'b0;
      size_err       <= 1'b0;
      overrun_cnt    <= '0;
      lines_ready    <= 1'b0;
      start_pending  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      hough_start <= 1'b0;
      busy_q      <= hough_busy;
      // Results become usable once an engine run we launched has finished.
      if (hough_start) begin
        start_pending <= 1'b1;
      end else if (start_pending && busy_q && !hough_busy) begin
        lines_ready   <= 1'b1;
        start_pending <= 1'b0;
      end

      unique case (state)
        StWaitCtrl: begin
          if (vip_ctrl_valid) begin
            width_out      <= width_in;
            height_out     <= height_in;
            interlaced_out <= interlaced_in;
            size_err       <= (width_in != ExpW) | (height_in != ExpH);
            state          <= StSendCtrl;
          end
        end
        StSendCtrl: begin
          if (!vip_ctrl_busy) begin
            overlay_en <= lines_ready & ~size_err;
            pix_x      <= '0;
            pix_y      <= '0;
            state      <= StStream;
          end
        end
        StStream: begin
          if (xfer) begin
            if (end_of_video) begin
              state <= StWaitCtrl;
              pix_x <= '0;
              pix_y <= '0;
              if (at_last && !size_err) begin
                if (!hough_busy) begin
                  hough_start <= 1'b1;
                end else if (~&overrun_cnt) begin
                  overrun_cnt <= overrun_cnt + 1'b1;
                end
              end
            end else if (at_last) begin
              state <= StDrain;
            end else if (pix_x == LastX) begin
              pix_x <= '0;
              pix_y <= pix_y + 16'd1;
            end else begin
              pix_x <= pix_x + 16'd1;
            end
          end
        end
        StDrain: begin
          if (xfer && end_of_video) begin
            state <= StWaitCtrl;
            pix_x <= '0;
            pix_y <= '0;
          end
        end
        default: state <= StWaitCtrl;
      endcase
    end
  end

endmodule

// File: tb/tb_hough_frame_sequencer.sv
// Randomized bench for hough_frame_sequencer with a frame-level reference model.
// Uses a small 16x6 frame so every scenario fits comfortably in simulation time.
module tb_hough_frame_sequencer;

  localparam int W = 16;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_in = 1'b1;
  logic        stall_out = 1'b0;
  logic        vip_ctrl_valid = 1'b0;
  logic [15:0] width_in = '0;
  logic [15:0] height_in = '0;
  logic [3:0]  interlaced_in = '0;
  logic        end_of_video = 1'b0;
  logic        vip_ctrl_busy = 1'b0;
  logic        hough_busy = 1'b0;
  logic        read, write, vip_ctrl_send, end_of_video_out;
  logic [15:0] width_out, height_out, pix_x, pix_y;
  logic [3:0]  interlaced_out;
  logic        pix_en, sof, eof, hough_start, overlay_en, size_err;
  logic [7:0]  overrun_cnt;

  hough_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .OVR_W(8)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .stall_out(stall_out),
    .vip_ctrl_valid(vip_ctrl_valid), .width_in(width_in), .height_in(height_in),
    .interlaced_in(interlaced_in), .end_of_video(end_of_video), .vip_ctrl_busy(vip_ctrl_busy),
    .read(read), .write(write), .vip_ctrl_send(vip_ctrl_send), .width_out(width_out),
    .height_out(height_out), .interlaced_out(interlaced_out),
    .end_of_video_out(end_of_video_out), .pix_en(pix_en), .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .eof(eof), .hough_start(hough_start), .hough_busy(hough_busy),
    .overlay_en(overlay_en), .size_err(size_err), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit go = 1'b0;
  bit busy_force = 1'b0;
  int eng = 0;
  int starts_seen = 0;
  int sends_seen = 0;
  int eof_x = -1;
  int eof_y = -1;

  // Reference model: phase 0 wait ctrl, 1 send ctrl, 2 stream, 3 drain; m_k = beat index.
  int          m_ph = 0, m_k = 0, m_ovr = 0;
  logic [15:0] m_w = '0, m_h = '0;
  logic [3:0]  m_il = '0;
  bit          m_serr = 0, m_ovl = 0, m_lr = 0, m_pend = 0, m_pbusy = 0, m_start = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Engine stand-in: busy for a random time after each start, or while forced.
  always @(posedge clk) begin
    #2;
    if (hough_start === 1'b1) eng = $urandom_range(5, 30);
    else if (eng > 0) eng--;
    hough_busy = busy_force || (eng > 0);
  end

  always @(negedge clk) begin : cmp
    bit xf, mv, pe, nstart;
    if (go) begin
      xf = !stall_in && !stall_out;
      mv = (m_ph == 2 || m_ph == 3) && xf;
      pe = (m_ph == 2) && xf && !m_serr;
      chk("read", read, mv);
      chk("write", write, mv);
      chk("ctrl_send", vip_ctrl_send, (m_ph == 1) && !vip_ctrl_busy);
      chk("pix_en", pix_en, pe);
      chk("sof", sof, pe && m_k == 0);
      chk("eof", eof, pe && m_k == W * H - 1);
      chk("eov_out", end_of_video_out, mv && end_of_video);
      if (pe) begin
        chk("pix_x", pix_x, m_k % W);
        chk("pix_y", pix_y, m_k / W);
      end
      chk("hough_start", hough_start, m_start);
      if (m_ph == 2) chk("overlay_en", overlay_en, m_ovl);
      chk("size_err", size_err, m_serr);
      chk("width_out", width_out, m_w);
      chk("height_out", height_out, m_h);
      chk("interlaced_out", interlaced_out, m_il);
      chk("overrun_cnt", overrun_cnt, m_ovr);
      if (hough_start === 1'b1) starts_seen++;
      if (vip_ctrl_send === 1'b1) sends_seen++;
      if (pix_en === 1'b1 && eof === 1'b1) begin
        eof_x = int'(pix_x);
        eof_y = int'(pix_y);
      end

      if (!rst) begin
        m_ph = 0; m_k = 0; m_w = '0; m_h = '0; m_il = '0; m_serr = 0; m_ovl = 0;
        m_lr = 0; m_pend = 0; m_pbusy = 0; m_start = 0; m_ovr = 0;
      end else begin
        nstart = 0;
        case (m_ph)
          0: if (vip_ctrl_valid) begin
            m_w = width_in; m_h = height_in; m_il = interlaced_in;
            m_serr = (width_in != 16'(W)) || (height_in != 16'(H));
            m_ph = 1;
          end
          1: if (!vip_ctrl_busy) begin
            m_ph = 2; m_k = 0; m_ovl = m_lr && !m_serr;
          end
          2: if (xf) begin
            if (end_of_video) begin
              if (m_k == W * H - 1 && !m_serr) begin
                if (!hough_busy) nstart = 1;
                else if (m_ovr < 255) m_ovr++;
              end
              m_ph = 0; m_k = 0;
            end else if (m_k == W * H - 1) m_ph = 3;
            else m_k++;
          end
          default: if (xf && end_of_video) begin
            m_ph = 0; m_k = 0;
          end
        endcase
        if (m_start) m_pend = 1;
        else if (m_pend && m_pbusy && !hough_busy) begin
          m_lr = 1; m_pend = 0;
        end
        m_pbusy = hough_busy;
        m_start = nstart;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      vip_ctrl_valid = 0; end_of_video = 0; stall_in = 1; stall_out = 0;
      vip_ctrl_busy = 0; busy_force = 0;
      @(posedge clk); #1;
    end
  endtask

  // One frame of n beats; busy forced until beat rel; reset pulsed at beat abort_at (-1 = none).
  task automatic frame(input int w, input int h, input int n, input int pct, input int rel,
                       input int abort_at);
    int beat = 0;
    int cyc = 0;
    int budget = n * 8 + 60;
    bit got;
    bit aborted = 0;
    logic [3:0] il = 4'($urandom_range(0, 15));
    while (beat < n && cyc < budget) begin
      vip_ctrl_valid = (cyc == 0);
      width_in = 16'(w); height_in = 16'(h); interlaced_in = il;
      stall_in = ($urandom_range(0, 99) < pct);
      stall_out = ($urandom_range(0, 99) < pct);
      vip_ctrl_busy = ($urandom_range(0, 99) < pct);
      end_of_video = (beat == n - 1);
      busy_force = (beat < rel);
      rst = !(beat == abort_at);
      @(negedge clk);
      got = read;
      @(posedge clk); #1;
      cyc++;
      if (!rst) begin
        rst = 1; aborted = 1;
        break;
      end
      if (got) beat++;
    end
    if (!aborted) chk("frame_complete", beat, n);
    vip_ctrl_valid = 0; end_of_video = 0; stall_in = 1; stall_out = 0; vip_ctrl_busy = 0;
  endtask

  initial begin
    @(posedge clk); #1;
    go = 1;
    @(posedge clk); #1;
    chk("reset_width_out", width_out, 0);
    chk("reset_hough_start", hough_start, 0);
    rst = 1;
    @(posedge clk); #1;

    frame(W, H, W * H, 0, 0, -1);          // clean frame
    chk("eof_x_lit", eof_x, 15);
    chk("eof_y_lit", eof_y, 5);
    idle(2);
    chk("starts_after_a", starts_seen, 1);
    idle(58);
    frame(W, H, W * H, 30, 0, -1);         // stalled frame
    idle(60);
    chk("starts_after_b", starts_seen, 2);
    frame(W, H, W * H, 0, 0, 50);          // reset mid-frame
    chk("abort_width_out", width_out, 0);
    idle(5);
    chk("starts_after_abort", starts_seen, 2);
    frame(W, H, W * H, 0, 0, -1);          // back-to-back trio
    frame(W, H, W * H, 20, 40, -1);
    frame(W, H, W * H, 0, 1000, -1);
    chk("overlay_lit", overlay_en, 1);
    chk("overrun_lit", overrun_cnt, 1);
    idle(60);
    chk("starts_after_trio", starts_seen, 4);
    frame(40, 30, 100, 30, 0, -1);         // size mismatch
    chk("size_err_lit", size_err, 1);
    idle(5);
    frame(W, H, 30, 0, 0, -1);             // short frame
    frame(W, H, W * H, 10, 0, -1);
    idle(60);
    chk("starts_after_short", starts_seen, 5);
    frame(W, H, W * H + 4, 0, 0, -1);      // long frame drains
    idle(5);
    chk("starts_final", starts_seen, 5);
    chk("sends_final", sends_seen, 10);
    chk("overrun_final", overrun_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got %0t expected completion", $time);
    $fatal(1);
  end

endmodule
